load_store_unit_l8: RTL and testbench
=====================================

# load_store_unit_l8

Parametrised successor execute-stage load-store unit. It accepts memory micro-ops from decode over the D→X interface and issues word-aligned requests with byte strobes on the memory interface. Up to `p_depth` requests can be outstanding, tracked in a circular in-flight buffer. Results retire to writeback over the X→W interface strictly in issue order, even when memory responses return out of order. It adds subword loads and stores (LB/LH/LBU/LHU/SB/SH) with sign or zero extension.

## Interface
- `p_seq_num_bits`, default 5: width of the sequence number carried D→X→W.
- `p_opaq_bits`, default 8: width of the memory opaque field. Must be ≥ log2(`p_depth`).
- `p_depth`, default 4: number of outstanding memory operations. Power of two, 2..2^`p_opaq_bits`.
- `clk`, input, 1: single clock. All state is updated on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `D`, D__XIntf slave (`p_seq_num_bits`): val/rdy plus pc, seq_num, op1, op2, waddr, uop, op3.mem_data. The preg and ppreg fields are ignored.
- `W`, X__WIntf master (`p_seq_num_bits`): val/rdy plus pc, seq_num, waddr, wdata, wen.
- `mem`, MemIntf master (`p_opaq_bits`): request val/rdy {op, opaque, addr, strb, data} and response val/rdy {op, opaque, addr, strb, data}.

## Operation
- **Address and accept.**
  - Effective address ea = op1 + op2, modulo 2^32. Lane offset off = ea[1:0].
  - `D.rdy` = !full && `mem.req_rdy`. A transfer occurs when `D.val` && `D.rdy`.
  - On accept, `mem.req_val` is asserted in the same cycle.
  - Request addr = {ea[31:2], 2'b00}. Request opaque = tail index, zero-extended.
- **Stores.**
  - op = write.
  - strb: SB → 4'b0001<<off; SH → 4'b0011<<off; SW → 4'b1111.
  - data = mem_data replicated into the selected lanes (byte ×4, half ×2).
- **Loads.** op = read, strb = 4'b1111.
- **Misalignment.** A misaligned SH/LH/LHU (off[0]=1) or SW/LW (off≠0) is forced aligned by clearing the offending offset bits. It is not flagged.
- **In-flight entry.** Each entry holds {valid, done, pc, seq_num, waddr, uop, off, data}. Accept writes the entry at tail, sets valid=1 and done=0, and advances tail.
- **Response.**
  - `mem.resp_rdy` is held at 1.
  - On `mem.resp_val`, the entry at index opaque[log2 p_depth-1:0] gets done=1 and latches resp data.
  - A response to an entry with !valid or done=1 is dropped with no state change.
- **Retire.**
  - `W.val` = head.valid && head.done.
  - On `W.val` && `W.rdy`: clear head.valid and advance head.
- **Load result.**
  - Shift resp data right by off×8.
  - LB/LH sign-extend bit 7/15. LBU/LHU zero-extend. LW passes through.
  - wen=1, waddr=entry waddr, wdata=result.
- **Store result.** wen=0, waddr=0, wdata=0. Stores wait for the write response before retiring, which preserves ordering.
- **Pointers and count.**
  - count = number of valid entries. full = (count == p_depth).
  - Head and tail wrap modulo p_depth.
  - Accept and retire in the same cycle leave count unchanged.
- **Full.** Accept is blocked while full, even if a retire happens in that cycle. There is no combinational path from `W.rdy` to `D.rdy`.
- **Other uops.** Any non-memory uop on D is never accepted. `D.rdy` may be high, but the unit treats it as a no-op: no allocation and no request. D is decoded upstream so this does not occur.

## Timing
- **Reset values.** head=0, tail=0, count=0, all entries valid=0 and done=0. `W.val`=0. `mem.resp_rdy`=1. `mem.req_val` follows `D.val`&&!full, so it is 0 when D is idle.
- **Reset mid-operation.** All in-flight entries are discarded. Late responses arriving after reset are dropped because their entries have valid=0.
- **Latency.**
  - Accept at cycle N → request at N.
  - Response at cycle M → done registered at M+1 → `W.val` at M+1 if the entry is head.
  - Minimum accept-to-retire is 2 cycles with zero-delay memory.
- **Back-to-back.**
  - One accept per cycle is sustained while count < p_depth and memory is ready.
  - One retire per cycle is sustained.
- **Simultaneous events.** A response and a retire may occur in the same cycle on different entries. A response to the current head is visible at `W` only in the following cycle.
- **Holding.** While `W.val`=1 and `W.rdy`=0, the W payload is held stable.

## Structure
- UArch package: rv_uop members LB/LH/LW/LBU/LHU/SB/SH/SW, plus helper functions is_load(uop), is_store(uop) and mem_size(uop) returning a 2-bit size.
- The entry struct is local to the module because it depends on `p_seq_num_bits`.
- One combinational sub-module, `LoadStoreAlignL8`: store lane/strobe/data insertion and load extraction/extension. It is shared with the top-level processor tests.
- The unit provides a `trace(level)` function showing head, tail, count and the issuing uop.

## Test plan
- **LW, depth 4.** op1=0x100, op2=0x4, mem[0x104]=0xDEADBEEF, waddr=5 → request read addr 0x104 strb F. W returns wen=1, waddr=5, wdata=0xDEADBEEF.
- **Subword loads.** mem[0x200]=0x80FF7F01.
  - LB ea=0x203 → 0xFFFFFF80. LBU ea=0x203 → 0x00000080.
  - LH ea=0x202 → 0xFFFF80FF. LHU ea=0x202 → 0x000080FF.
- **Subword stores.** SB ea=0x301 data 0xAB → strb 0010, data 0xABABABAB. SH ea=0x302 data 0x1234 → strb 1100. Each retires with wen=0, waddr=0, wdata=0.
- **Fill and stall.** With the memory response delay high, 4 accepts leave `D.rdy`=0 on the 5th. `D.rdy` returns to 1 the cycle after the first retire. Seq nums 0..4 retire in order.
- **Out-of-order responses.** A memory model answers opaque 1 before 0. W still delivers seq 0 then 1. A response carrying the opaque of a freed slot is dropped.
- **Mid-flight reset.** 3 loads are outstanding when `rst` is pulled low asynchronously. `W.val`=0 and count=0 immediately. Late responses are ignored, and a new LW after reset retires correctly.

Source files
------------

// File: rtl/load_store_unit_l8_pkg.sv
// Shared micro-op encodings and decode helpers for the load-store unit
// and the processor-level tests.
package load_store_unit_l8_pkg;

    typedef enum logic [3:0] {
        UOP_NOP = 4'd0,
        UOP_LB  = 4'd1,
        UOP_LH  = 4'd2,
        UOP_LW  = 4'd3,
        UOP_LBU = 4'd4,
        UOP_LHU = 4'd5,
        UOP_SB  = 4'd6,
        UOP_SH  = 4'd7,
        UOP_SW  = 4'd8,
        UOP_ALU = 4'd9
    } rv_uop_e;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    function automatic logic is_load(input rv_uop_e uop);
        return (uop == UOP_LB) || (uop == UOP_LH) || (uop == UOP_LW) ||
               (uop == UOP_LBU) || (uop == UOP_LHU);
    endfunction

    function automatic logic is_store(input rv_uop_e uop);
        return (uop == UOP_SB) || (uop == UOP_SH) || (uop == UOP_SW);
    endfunction

    function automatic logic [1:0] mem_size(input rv_uop_e uop);
        case (uop)
            UOP_LB, UOP_LBU, UOP_SB: return SIZE_B;
            UOP_LH, UOP_LHU, UOP_SH: return SIZE_H;
            default:                 return SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_l8_align.sv
// Combinational lane logic: request offset alignment, store strobe/data
// insertion, and load extraction with sign or zero extension.
module load_store_unit_l8_align
    import load_store_unit_l8_pkg::*;
(
    input  rv_uop_e     req_uop,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_data,
    output logic [1:0]  req_off_aligned,
    output logic [3:0]  req_strb,
    output logic [31:0] req_wdata,
    input  rv_uop_e     ld_uop,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_data,
    output logic [31:0] ld_result
);

    logic [31:0] ld_shifted;

    // Misaligned halves/words are silently pulled down to their natural boundary.
    always_comb begin
        req_off_aligned = req_off;
        req_strb        = 4'b1111;
        req_wdata       = req_data;
        case (mem_size(req_uop))
            SIZE_B: begin
                if (is_store(req_uop)) begin
                    req_strb  = 4'b0001 << req_off;
                    req_wdata = {4{req_data[7:0]}};
                end
            end
            SIZE_H: begin
                req_off_aligned = {req_off[1], 1'b0};
                if (is_store(req_uop)) begin
                    req_strb  = 4'b0011 << {req_off[1], 1'b0};
                    req_wdata = {2{req_data[15:0]}};
                end
            end
            default: begin
                req_off_aligned = 2'b00;
            end
        endcase
    end

    always_comb begin
        ld_shifted = ld_data >> {ld_off, 3'b000};
        case (ld_uop)
            UOP_LB:  ld_result = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            UOP_LBU: ld_result = {24'h0, ld_shifted[7:0]};
            UOP_LH:  ld_result = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            UOP_LHU: ld_result = {16'h0, ld_shifted[15:0]};
            default: ld_result = ld_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit_l8.sv
// Execute-stage load-store unit: issues memory requests, tracks up to p_depth
// in-flight ops in a circular buffer and retires them strictly in issue order.
module load_store_unit_l8
    import load_store_unit_l8_pkg::*;
#(
    parameter int p_seq_num_bits = 5,
    parameter int p_opaq_bits    = 8,
    parameter int p_depth        = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      d_val,
    output logic                      d_rdy,
    input  logic [31:0]               d_pc,
    input  logic [p_seq_num_bits-1:0] d_seq_num,
    input  logic [31:0]               d_op1,
    input  logic [31:0]               d_op2,
    input  logic [4:0]                d_waddr,
    input  rv_uop_e                   d_uop,
    input  logic [31:0]               d_mem_data,

    output logic                      w_val,
    input  logic                      w_rdy,
    output logic [31:0]               w_pc,
    output logic [p_seq_num_bits-1:0] w_seq_num,
    output logic [4:0]                w_waddr,
    output logic [31:0]               w_wdata,
    output logic                      w_wen,

    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output mem_op_e                   mem_req_op,
    output logic [p_opaq_bits-1:0]    mem_req_opaque,
    output logic [31:0]               mem_req_addr,
    output logic [3:0]                mem_req_strb,
    output logic [31:0]               mem_req_data,

    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy,
    input  mem_op_e                   mem_resp_op,
    input  logic [p_opaq_bits-1:0]    mem_resp_opaque,
    input  logic [31:0]               mem_resp_addr,
    input  logic [3:0]                mem_resp_strb,
    input  logic [31:0]               mem_resp_data
);

    localparam int IDX_W = $clog2(p_depth);
    localparam int CNT_W = $clog2(p_depth + 1);

    typedef struct packed {
        logic                      valid;
        logic                      done;
        logic [31:0]               pc;
        logic [p_seq_num_bits-1:0] seq_num;
        logic [4:0]                waddr;
        rv_uop_e                   uop;
        logic [1:0]                off;
        logic [31:0]               data;
    } entry_t;

    entry_t           entries [p_depth];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             full;
    logic             accept;
    logic             retire;
    logic [31:0]      ea;
    logic [1:0]       off_aligned;
    logic [IDX_W-1:0] resp_idx;
    logic [31:0]      ld_result;
    entry_t           head_e;
    logic             unused_resp;

    assign ea       = d_op1 + d_op2;
    assign full     = (count == CNT_W'(p_depth));
    assign d_rdy    = !full && mem_req_rdy;
    assign resp_idx = mem_resp_opaque[IDX_W-1:0];
    assign head_e   = entries[head];

    // Non-memory uops see d_rdy but never allocate or issue.
    assign mem_req_val    = d_val && !full && (is_load(d_uop) || is_store(d_uop));
    assign accept         = mem_req_val && mem_req_rdy;
    assign mem_req_op     = is_store(d_uop) ? MEM_WRITE : MEM_READ;
    assign mem_req_opaque = p_opaq_bits'(tail);
    assign mem_req_addr   = {ea[31:2], 2'b00};
    assign mem_resp_rdy   = 1'b1;

    assign unused_resp = ^{mem_resp_op, mem_resp_addr, mem_resp_strb, mem_resp_opaque};

    load_store_unit_l8_align u_align (
        .req_uop         (d_uop),
        .req_off         (ea[1:0]),
        .req_data        (d_mem_data),
        .req_off_aligned (off_aligned),
        .req_strb        (mem_req_strb),
        .req_wdata       (mem_req_data),
        .ld_uop          (head_e.uop),
        .ld_off          (head_e.off),
        .ld_data         (head_e.data),
        .ld_result       (ld_result)
    );

    assign w_val     = head_e.valid && head_e.done;
    assign retire    = w_val && w_rdy;
    assign w_pc      = head_e.pc;
    assign w_seq_num = head_e.seq_num;
    assign w_wen     = is_load(head_e.uop);
    assign w_waddr   = is_load(head_e.uop) ? head_e.waddr : 5'd0;
    assign w_wdata   = is_load(head_e.uop) ? ld_result : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < p_depth; i++) begin
                entries[i] <= '0;
            end
        end else begin
            // Stale or duplicate responses fall through with no effect.
            if (mem_resp_val && entries[resp_idx].valid && !entries[resp_idx].done) begin
                entries[resp_idx].done <= 1'b1;
                entries[resp_idx].data <= mem_resp_data;
            end
            if (retire) begin
                entries[head].valid <= 1'b0;
                head                <= head + IDX_W'(1);
            end
            if (accept) begin
                entries[tail] <= '{valid:   1'b1,
                                   done:    1'b0,
                                   pc:      d_pc,
                                   seq_num: d_seq_num,
                                   waddr:   d_waddr,
                                   uop:     d_uop,
                                   off:     off_aligned,
                                   data:    32'd0};
                tail          <= tail + IDX_W'(1);
            end
            case ({accept, retire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    function automatic string trace(input int level);
        if (level > 0) begin
            return $sformatf("h=%0d t=%0d c=%0d uop=%s", head, tail, count,
                             accept ? d_uop.name() : "-");
        end
        return $sformatf("h=%0d t=%0d c=%0d", head, tail, count);
    endfunction

endmodule

// File: tb/tb_load_store_unit_l8.sv
// Directed bench for load_store_unit_l8: vector table for single ops, plus
// sequences for fill/stall, out-of-order responses and mid-flight reset.
module tb_load_store_unit_l8;
    import load_store_unit_l8_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_val, d_rdy;
    logic [31:0] d_pc, d_op1, d_op2, d_mem_data;
    logic [4:0]  d_seq_num, d_waddr;
    rv_uop_e     d_uop;
    logic        w_val, w_rdy, w_wen;
    logic [31:0] w_pc, w_wdata;
    logic [4:0]  w_seq_num, w_waddr;
    logic        mem_req_val, mem_req_rdy;
    mem_op_e     mem_req_op;
    logic [7:0]  mem_req_opaque;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [3:0]  mem_req_strb;
    logic        mem_resp_val, mem_resp_rdy;
    mem_op_e     mem_resp_op;
    logic [7:0]  mem_resp_opaque;
    logic [31:0] mem_resp_addr, mem_resp_data;
    logic [3:0]  mem_resp_strb;

    always #5 clk = ~clk;

    load_store_unit_l8 dut (
        .clk(clk), .rst(rst),
        .d_val(d_val), .d_rdy(d_rdy), .d_pc(d_pc), .d_seq_num(d_seq_num),
        .d_op1(d_op1), .d_op2(d_op2), .d_waddr(d_waddr), .d_uop(d_uop),
        .d_mem_data(d_mem_data),
        .w_val(w_val), .w_rdy(w_rdy), .w_pc(w_pc), .w_seq_num(w_seq_num),
        .w_waddr(w_waddr), .w_wdata(w_wdata), .w_wen(w_wen),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_op(mem_req_op),
        .mem_req_opaque(mem_req_opaque), .mem_req_addr(mem_req_addr),
        .mem_req_strb(mem_req_strb), .mem_req_data(mem_req_data),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_op(mem_resp_op),
        .mem_resp_opaque(mem_resp_opaque), .mem_resp_addr(mem_resp_addr),
        .mem_resp_strb(mem_resp_strb), .mem_resp_data(mem_resp_data)
    );

    typedef struct {
        rv_uop_e     uop;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sdata;
        logic [4:0]  waddr;
        logic [31:0] mword;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        mem_op_e     exp_op;
        logic [31:0] exp_req_data;
        logic        exp_wen;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic        op;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } req_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tail_m   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic issue(input rv_uop_e uop, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [31:0] sdata, input logic [4:0] waddr,
                         input logic [4:0] seq, output req_t r);
        int n = 0;
        d_val = 1'b1; d_uop = uop; d_op1 = op1; d_op2 = op2; d_mem_data = sdata;
        d_waddr = waddr; d_seq_num = seq; d_pc = 32'h1000 + 32'(seq) * 4;
        #1;
        while (!d_rdy && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!d_rdy) timeout("issue_wait");
        r.op = mem_req_op; r.opaque = mem_req_opaque; r.addr = mem_req_addr;
        r.strb = mem_req_strb; r.data = mem_req_data;
        @(posedge clk); #1;
        d_val = 1'b0;
        tail_m = (tail_m + 1) % 4;
    endtask

    task automatic respond(input int slot, input logic [31:0] data);
        mem_resp_val = 1'b1; mem_resp_opaque = 8'(slot); mem_resp_data = data;
        @(posedge clk); #1;
        mem_resp_val = 1'b0;
    endtask

    task automatic expect_w(input string name, input logic [4:0] seq, input logic wen,
                            input logic [4:0] waddr, input logic [31:0] wdata);
        int n = 0;
        while (!w_val && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!w_val) begin
            timeout({name, "_wval"});
            return;
        end
        check({name, "_seq"}, w_seq_num, seq);
        check({name, "_pc"}, w_pc, 32'h1000 + 32'(seq) * 4);
        check({name, "_wen"}, w_wen, wen);
        check({name, "_waddr"}, w_waddr, waddr);
        check({name, "_wdata"}, w_wdata, wdata);
        w_rdy = 1'b1;
        @(posedge clk); #1;
        w_rdy = 1'b0;
    endtask

    initial begin
        req_t r;
        int   slot;
        int   s [5];

        vecs[0]  = '{UOP_LW,  32'h100, 32'h4, 32'h0, 5'd5, 32'hDEADBEEF, 32'h104, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[1]  = '{UOP_LB,  32'h200, 32'h3, 32'h0, 5'd1, 32'h80FF7F01, 32'h200, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd1, 32'hFFFFFF80};
        vecs[2]  = '{UOP_LBU, 32'h200, 32'h3, 32'h0, 5'd2, 32'h80FF7F01, 32'h200, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd2, 32'h00000080};
        vecs[3]  = '{UOP_LH,  32'h200, 32'h2, 32'h0, 5'd3, 32'h80FF7F01, 32'h200, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd3, 32'hFFFF80FF};
        vecs[4]  = '{UOP_LHU, 32'h1FF, 32'h3, 32'h0, 5'd4, 32'h80FF7F01, 32'h200, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd4, 32'h000080FF};
        vecs[5]  = '{UOP_LB,  32'h200, 32'h1, 32'h0, 5'd6, 32'h80FF7F01, 32'h200, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd6, 32'h0000007F};
        vecs[6]  = '{UOP_LH,  32'h200, 32'h3, 32'h0, 5'd7, 32'h80FF7F01, 32'h200, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd7, 32'hFFFF80FF};
        vecs[7]  = '{UOP_LW,  32'h200, 32'h2, 32'h0, 5'd8, 32'h80FF7F01, 32'h200, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd8, 32'h80FF7F01};
        vecs[8]  = '{UOP_LHU, 32'h200, 32'h1, 32'h0, 5'd9, 32'h80FF7F01, 32'h200, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd9, 32'h00007F01};
        vecs[9]  = '{UOP_SB,  32'h300, 32'h1, 32'h123456AB, 5'd7, 32'hFFFFFFFF, 32'h300, 4'h2, MEM_WRITE, 32'hABABABAB, 1'b0, 5'd0, 32'h0};
        vecs[10] = '{UOP_SH,  32'h300, 32'h2, 32'hFFFF1234, 5'd3, 32'hFFFFFFFF, 32'h300, 4'hC, MEM_WRITE, 32'h12341234, 1'b0, 5'd0, 32'h0};
        vecs[11] = '{UOP_SW,  32'h400, 32'h0, 32'hCAFEF00D, 5'd2, 32'hFFFFFFFF, 32'h400, 4'hF, MEM_WRITE, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0};
        vecs[12] = '{UOP_SH,  32'h300, 32'h1, 32'h00005678, 5'd1, 32'hFFFFFFFF, 32'h300, 4'h3, MEM_WRITE, 32'h56785678, 1'b0, 5'd0, 32'h0};
        vecs[13] = '{UOP_LW,  32'hFFFFFFFF, 32'h5, 32'h0, 5'd31, 32'h11223344, 32'h4, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd31, 32'h11223344};
        vecs[14] = '{UOP_SB,  32'h300, 32'h3, 32'h000000EE, 5'd4, 32'h0, 32'h300, 4'h8, MEM_WRITE, 32'hEEEEEEEE, 1'b0, 5'd0, 32'h0};
        vecs[15] = '{UOP_LB,  32'h200, 32'h0, 32'h0, 5'd10, 32'h80FF7F01, 32'h200, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd10, 32'h00000001};
        vecs[16] = '{UOP_LH,  32'h200, 32'h0, 32'h0, 5'd11, 32'h80FF7F01, 32'h200, 4'hF, MEM_READ, 32'h0, 1'b1, 5'd11, 32'h00007F01};

        rst = 1'b0;
        d_val = 1'b0; d_pc = '0; d_seq_num = '0; d_op1 = '0; d_op2 = '0;
        d_waddr = '0; d_uop = UOP_NOP; d_mem_data = '0;
        w_rdy = 1'b0; mem_req_rdy = 1'b1;
        mem_resp_val = 1'b0; mem_resp_op = MEM_READ; mem_resp_opaque = '0;
        mem_resp_addr = '0; mem_resp_strb = '0; mem_resp_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_wval", w_val, 1'b0);
        check("rst_resp_rdy", mem_resp_rdy, 1'b1);
        check("rst_req_val", mem_req_val, 1'b0);
        check("rst_d_rdy", d_rdy, 1'b1);
        rst = 1'b1;
        mem_req_rdy = 1'b0;
        #1;
        check("req_rdy_low_d_rdy", d_rdy, 1'b0);
        mem_req_rdy = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            slot = tail_m;
            issue(vecs[i].uop, vecs[i].op1, vecs[i].op2, vecs[i].sdata, vecs[i].waddr, 5'(i), r);
            check($sformatf("v%0d_addr", i), r.addr, vecs[i].exp_addr);
            check($sformatf("v%0d_strb", i), r.strb, vecs[i].exp_strb);
            check($sformatf("v%0d_op", i), r.op, vecs[i].exp_op);
            check($sformatf("v%0d_opaque", i), r.opaque, slot);
            if (vecs[i].exp_op == MEM_WRITE)
                check($sformatf("v%0d_req_data", i), r.data, vecs[i].exp_req_data);
            check($sformatf("v%0d_wval_pre", i), w_val, 1'b0);
            respond(slot, vecs[i].mword);
            check($sformatf("v%0d_wval_post", i), w_val, 1'b1);
            expect_w($sformatf("v%0d", i), 5'(i), vecs[i].exp_wen, vecs[i].exp_waddr, vecs[i].exp_wdata);
        end

        // Fill to depth, then the fifth stalls until the first retire.
        for (int k = 0; k < 4; k++) begin
            s[k] = tail_m;
            issue(UOP_LW, 32'h500, 32'(k * 4), 32'h0, 5'(k + 1), 5'(k), r);
        end
        s[4] = tail_m;
        d_val = 1'b1; d_uop = UOP_LW; d_op1 = 32'h510; d_op2 = 32'h0;
        d_seq_num = 5'd4; d_pc = 32'h1000 + 32'd16; d_waddr = 5'd5;
        #1;
        check("fill_d_rdy", d_rdy, 1'b0);
        check("fill_req_val", mem_req_val, 1'b0);
        respond(s[0], 32'hA0);
        w_rdy = 1'b1;
        #1;
        check("fill_no_comb_path", d_rdy, 1'b0);
        check("fill_head_seq", w_seq_num, 5'd0);
        check("fill_head_wval", w_val, 1'b1);
        @(posedge clk); #1;
        w_rdy = 1'b0;
        check("fill_d_rdy_after_retire", d_rdy, 1'b1);
        check("fill_wrap_opaque", mem_req_opaque, s[4]);
        @(posedge clk); #1;
        d_val = 1'b0;
        tail_m = (tail_m + 1) % 4;
        for (int k = 1; k < 5; k++) begin
            respond(s[k], 32'hA0 + 32'(k));
            expect_w($sformatf("fill_ret%0d", k), 5'(k), 1'b1, 5'(k + 1), 32'hA0 + 32'(k));
        end

        // Out-of-order responses, duplicate and stale responses.
        s[0] = tail_m;
        issue(UOP_LW, 32'h600, 32'h0, 32'h0, 5'd12, 5'd10, r);
        s[1] = tail_m;
        issue(UOP_LW, 32'h604, 32'h0, 32'h0, 5'd13, 5'd11, r);
        respond(s[1], 32'h2222);
        check("ooo_head_not_done", w_val, 1'b0);
        respond(s[0], 32'h1111);
        check("ooo_head_ready", w_val, 1'b1);
        respond(s[0], 32'h7777);
        check("ooo_dup_dropped", w_wdata, 32'h1111);
        expect_w("ooo_first", 5'd10, 1'b1, 5'd12, 32'h1111);
        expect_w("ooo_second", 5'd11, 1'b1, 5'd13, 32'h2222);
        respond(s[0], 32'hBAD0BAD0);
        check("ooo_stale_wval", w_val, 1'b0);
        slot = tail_m;
        issue(UOP_LW, 32'h608, 32'h0, 32'h0, 5'd14, 5'd12, r);
        respond(slot, 32'h3333);
        expect_w("ooo_after_stale", 5'd12, 1'b1, 5'd14, 32'h3333);

        // Asynchronous reset with three loads outstanding.
        s[0] = tail_m;
        issue(UOP_LW, 32'h700, 32'h0, 32'h0, 5'd20, 5'd20, r);
        s[1] = tail_m;
        issue(UOP_LW, 32'h704, 32'h0, 32'h0, 5'd21, 5'd21, r);
        s[2] = tail_m;
        issue(UOP_LW, 32'h708, 32'h0, 32'h0, 5'd22, 5'd22, r);
        respond(s[0], 32'h4444);
        check("mrst_wval_before", w_val, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_wval", w_val, 1'b0);
        check("mrst_d_rdy", d_rdy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        tail_m = 0;
        respond(s[1], 32'hDEAD0001);
        respond(s[2], 32'hDEAD0002);
        for (int k = 0; k < 4; k++) respond(k, 32'hDEAD0010 + 32'(k));
        check("mrst_late_dropped", w_val, 1'b0);
        issue(UOP_LW, 32'h100, 32'h4, 32'h0, 5'd9, 5'd30, r);
        check("mrst_new_opaque", r.opaque, 8'd0);
        check("mrst_new_addr", r.addr, 32'h104);
        check("mrst_count_cleared", d_rdy, 1'b1);
        respond(0, 32'hA5A5A5A5);
        expect_w("mrst_new", 5'd30, 1'b1, 5'd9, 32'hA5A5A5A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
